// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
//   dmemState_e : controller FSM state encoding (2 bits)
//   dmemRsp_t   : response payload (error flag + load data)
package dmem_pkg;

    localparam int unsigned DMEM_DATAWIDTH = 32;
    localparam logic [3:0]  BE_FULL        = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } dmemState_e;

    typedef struct packed {
        logic                      error;
        logic [DMEM_DATAWIDTH-1:0] data;
    } dmemRsp_t;

endpackage

// File: rtl/dmem_addr_chk.sv
// Combinational range / byte-enable check for a core data-memory request.
//   addr       : byte address from the core
//   byteEnable : requested byte lanes
//   error      : request falls outside the SRAM window or has no lanes set
//   wordAddr   : SRAM word address (valid only when error is 0)
module dmem_addr_chk
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic [DMEM_DATAWIDTH-1:0] addr,
    input  logic [3:0]                byteEnable,
    output logic                      error,
    output logic [DEPTH_LOG2-1:0]     wordAddr
);

    // Window size in bytes; one extra bit so DEPTH_LOG2 = 30 cannot wrap.
    localparam logic [32:0] SPAN_BYTES = 33'(4) << DEPTH_LOG2;

    logic [DMEM_DATAWIDTH-1:0] offset;

    // Addr[1:0] only matters through the comparison; lanes are already encoded.
    always_comb begin
        offset   = addr - BASE_ADDR;
        error    = (addr < BASE_ADDR)
                 || ({1'b0, offset} >= SPAN_BYTES)
                 || (byteEnable == 4'b0000);
        wordAddr = offset[DEPTH_LOG2+1:2];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the core load/store path and a
// synchronous single-port SRAM with byte enables.
//   DMEM_Req_*  : core request handshake (one outstanding request)
//   DMEM_Rsp_*  : response handshake (load data / write ack / error)
//   DMEM_Sram_* : SRAM chip select, write enable, byte mask, address, data
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                      DMEM_Clk_In,
    input  logic                      DMEM_Reset_In,
    input  logic                      DMEM_Req_Valid_In,
    output logic                      DMEM_Req_Ready_Out,
    input  logic                      DMEM_Req_Write_In,
    input  logic [DMEM_DATAWIDTH-1:0] DMEM_Req_Addr_InBUS,
    input  logic [3:0]                DMEM_Req_Byteenable_InBUS,
    input  logic [DMEM_DATAWIDTH-1:0] DMEM_Req_Writedata_InBUS,
    output logic                      DMEM_Rsp_Valid_Out,
    input  logic                      DMEM_Rsp_Ready_In,
    output logic [DMEM_DATAWIDTH-1:0] DMEM_Rsp_Readdata_OutBUS,
    output logic                      DMEM_Rsp_Error_Out,
    output logic                      DMEM_Sram_Cs_Out,
    output logic                      DMEM_Sram_We_Out,
    output logic [3:0]                DMEM_Sram_Be_OutBUS,
    output logic [DEPTH_LOG2-1:0]     DMEM_Sram_Addr_OutBUS,
    output logic [DMEM_DATAWIDTH-1:0] DMEM_Sram_Wdata_OutBUS,
    input  logic [DMEM_DATAWIDTH-1:0] DMEM_Sram_Rdata_InBUS
);

    localparam int unsigned CNT_W = 2;

    dmemState_e                state;
    dmemState_e                stateNext;
    logic [CNT_W-1:0]          waitCnt;
    logic [CNT_W-1:0]          waitCntNext;
    logic                      accept;
    logic                      captureRd;
    logic                      chkError;
    logic [DEPTH_LOG2-1:0]     chkWord;

    logic                      reqWrite;
    logic                      reqReadyQ;
    logic                      rspValidQ;
    dmemRsp_t                  rspQ;
    logic                      csQ;
    logic                      weQ;
    logic [3:0]                beQ;
    logic [DEPTH_LOG2-1:0]     sramAddrQ;
    logic [DMEM_DATAWIDTH-1:0] sramWdataQ;

    dmem_addr_chk #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_addr_chk (
        .addr       (DMEM_Req_Addr_InBUS),
        .byteEnable (DMEM_Req_Byteenable_InBUS),
        .error      (chkError),
        .wordAddr   (chkWord)
    );

    // State and wait-counter register.
    always_ff @(posedge DMEM_Clk_In) begin
        if (DMEM_Reset_In) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Next-state logic. Acceptance uses the registered ready so that no
    // request is taken in the cycle straight after reset.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        captureRd   = 1'b0;
        case (state)
            IDLE: begin
                if (DMEM_Req_Valid_In && reqReadyQ) begin
                    accept    = 1'b1;
                    stateNext = chkError ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (reqWrite) begin
                    stateNext = RESP;
                end else begin
                    stateNext   = WAIT;
                    waitCntNext = CNT_W'(RD_LATENCY - 1);
                end
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    captureRd = 1'b1;
                    stateNext = RESP;
                end else begin
                    waitCntNext = waitCnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (DMEM_Rsp_Ready_In) begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    // Registered outputs, derived from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge DMEM_Clk_In) begin
        if (DMEM_Reset_In) begin
            reqWrite   <= 1'b0;
            reqReadyQ  <= 1'b0;
            rspValidQ  <= 1'b0;
            rspQ       <= '0;
            csQ        <= 1'b0;
            weQ        <= 1'b0;
            beQ        <= '0;
            sramAddrQ  <= '0;
            sramWdataQ <= '0;
        end else begin
            reqReadyQ <= (stateNext == IDLE);
            rspValidQ <= (stateNext == RESP);
            csQ       <= (stateNext == ACCESS);
            weQ       <= (stateNext == ACCESS) && DMEM_Req_Write_In;
            if (stateNext == ACCESS) begin
                beQ <= DMEM_Req_Write_In ? DMEM_Req_Byteenable_InBUS : BE_FULL;
            end else begin
                beQ <= '0;
            end

            if (accept) begin
                reqWrite   <= DMEM_Req_Write_In;
                rspQ.error <= chkError;
                rspQ.data  <= '0;
                // Rejected requests leave the SRAM-facing registers untouched.
                if (!chkError) begin
                    sramAddrQ  <= chkWord;
                    sramWdataQ <= DMEM_Req_Writedata_InBUS;
                end
            end

            if (captureRd) begin
                rspQ.data <= DMEM_Sram_Rdata_InBUS;
            end
        end
    end

    assign DMEM_Req_Ready_Out       = reqReadyQ;
    assign DMEM_Rsp_Valid_Out       = rspValidQ;
    assign DMEM_Rsp_Readdata_OutBUS = rspQ.data;
    assign DMEM_Rsp_Error_Out       = rspQ.error;
    assign DMEM_Sram_Cs_Out         = csQ;
    assign DMEM_Sram_We_Out         = weQ;
    assign DMEM_Sram_Be_OutBUS      = beQ;
    assign DMEM_Sram_Addr_OutBUS    = sramAddrQ;
    assign DMEM_Sram_Wdata_OutBUS   = sramWdataQ;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: instance 0 (RD_LATENCY=1) is tracked cycle by cycle
// against a transaction-level model; instance 1 (RD_LATENCY=3) is checked
// with directed literal expectations.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWrite  [2];
    logic [31:0] reqAddr   [2];
    logic [3:0]  reqBe     [2];
    logic [31:0] reqWdata  [2];
    logic        rspValid  [2];
    logic        rspReady  [2];
    logic [31:0] rspData   [2];
    logic        rspErr    [2];
    logic        sramCs    [2];
    logic        sramWe    [2];
    logic [3:0]  sramBe    [2];
    logic [9:0]  sramAddr  [2];
    logic [31:0] sramWdata [2];
    logic [31:0] sramRdata [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        dmem_ctrl #(
            .BASE_ADDR  (BASE),
            .DEPTH_LOG2 (10),
            .RD_LATENCY (LAT)
        ) u_dut (
            .DMEM_Clk_In               (clk),
            .DMEM_Reset_In             (rst),
            .DMEM_Req_Valid_In         (reqValid[g]),
            .DMEM_Req_Ready_Out        (reqReady[g]),
            .DMEM_Req_Write_In         (reqWrite[g]),
            .DMEM_Req_Addr_InBUS       (reqAddr[g]),
            .DMEM_Req_Byteenable_InBUS (reqBe[g]),
            .DMEM_Req_Writedata_InBUS  (reqWdata[g]),
            .DMEM_Rsp_Valid_Out        (rspValid[g]),
            .DMEM_Rsp_Ready_In         (rspReady[g]),
            .DMEM_Rsp_Readdata_OutBUS  (rspData[g]),
            .DMEM_Rsp_Error_Out        (rspErr[g]),
            .DMEM_Sram_Cs_Out          (sramCs[g]),
            .DMEM_Sram_We_Out          (sramWe[g]),
            .DMEM_Sram_Be_OutBUS       (sramBe[g]),
            .DMEM_Sram_Addr_OutBUS     (sramAddr[g]),
            .DMEM_Sram_Wdata_OutBUS    (sramWdata[g]),
            .DMEM_Sram_Rdata_InBUS     (sramRdata[g])
        );

        // SRAM model: read data is valid only in the single cycle LAT after
        // the chip-select cycle; any other cycle shows a junk pattern.
        logic [31:0] mem      [1024];
        logic [31:0] pipeData [LAT];
        logic        pipeVld  [LAT];

        initial begin
            for (int w = 0; w < 1024; w++) mem[w] = 32'hA500_0000 | 32'(w);
            for (int k = 0; k < int'(LAT); k++) begin
                pipeVld[k]  = 1'b0;
                pipeData[k] = '0;
            end
        end

        always @(posedge clk) begin
            if (sramCs[g] && sramWe[g]) begin
                for (int b = 0; b < 4; b++)
                    if (sramBe[g][b]) mem[sramAddr[g]][8*b +: 8] <= sramWdata[g][8*b +: 8];
            end
            pipeVld[0]  <= sramCs[g] && !sramWe[g];
            pipeData[0] <= mem[sramAddr[g]];
            for (int k = 1; k < int'(LAT); k++) begin
                pipeVld[k]  <= pipeVld[k-1];
                pipeData[k] <= pipeData[k-1];
            end
        end

        assign sramRdata[g] = pipeVld[LAT-1] ? pipeData[LAT-1] : 32'hBAD0_0BAD;
    end

    // Transaction-level model of instance 0.
    logic [31:0] refMem [1024];
    initial for (int w = 0; w < 1024; w++) refMem[w] = 32'hA500_0000 | 32'(w);

    logic        mValid     = 1'b0;
    logic        mJustReset = 1'b0;
    logic        mBusy      = 1'b0;
    logic        mReady     = 1'b0;
    logic        mErr       = 1'b0;
    logic        mWrite     = 1'b0;
    logic [3:0]  mBe        = '0;
    logic [31:0] mData      = '0;
    logic [31:0] mSramAddr  = '0;
    logic [31:0] mWdata     = '0;
    int          mCyc       = 0;
    int          mLat       = 0;

    always @(posedge clk) begin
        if (rst) begin
            mValid = 1'b1; mJustReset = 1'b1; mBusy = 1'b0; mReady = 1'b0;
            mSramAddr = '0; mWdata = '0;
        end else begin
            mJustReset = 1'b0;
            if (mBusy) begin
                if (mCyc >= mLat && rspReady[0]) mBusy = 1'b0;
                else mCyc++;
            end else if (mReady && reqValid[0]) begin
                int w;
                mErr   = (reqAddr[0] < BASE) || ((reqAddr[0] - BASE) >= 32'h1000) || (reqBe[0] == 4'h0);
                mWrite = reqWrite[0];
                mBe    = reqBe[0];
                w      = int'(((reqAddr[0] - BASE) >> 2) & 32'h3FF);
                mLat   = mErr ? 1 : (mWrite ? 2 : 3);
                mData  = '0;
                if (!mErr) begin
                    mSramAddr = 32'(w);
                    mWdata    = reqWdata[0];
                    if (mWrite) begin
                        for (int b = 0; b < 4; b++)
                            if (mBe[b]) refMem[w][8*b +: 8] = reqWdata[0][8*b +: 8];
                    end else begin
                        mData = refMem[w];
                    end
                end
                mBusy = 1'b1;
                mCyc  = 1;
            end else begin
                mReady = 1'b1;
            end
        end
    end

    // Compare instance 0 against the model every cycle.
    always @(negedge clk) begin
        if (mValid) begin
            logic expValid;
            logic expCs;
            expValid = mBusy && (mCyc >= mLat);
            expCs    = mBusy && !mErr && (mCyc == 1);
            chk("m_req_ready", 32'(reqReady[0]), 32'(mReady && !mBusy));
            chk("m_rsp_valid", 32'(rspValid[0]), 32'(expValid));
            if (expValid || mJustReset) begin
                chk("m_rsp_data", rspData[0], mJustReset ? 32'h0 : mData);
                chk("m_rsp_err", 32'(rspErr[0]), mJustReset ? 32'h0 : 32'(mErr));
            end
            chk("m_cs", 32'(sramCs[0]), 32'(expCs));
            chk("m_we", 32'(sramWe[0]), 32'(expCs && mWrite));
            chk("m_be", 32'(sramBe[0]), expCs ? 32'(mWrite ? mBe : 4'hF) : 32'h0);
            chk("m_sram_addr", 32'(sramAddr[0]), mSramAddr);
            chk("m_sram_wdata", sramWdata[0], mWdata);
        end
    end

    // Issue one request and check hand-computed latency, data and SRAM strobe.
    task automatic doReq(input int i, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input int hold,
                         input int expLat, input logic [31:0] expData, input logic expErr,
                         input logic [9:0] expWord, input logic [3:0] expSramBe);
        int n;
        int lat;
        @(posedge clk); #1;
        reqValid[i] = 1'b1; reqWrite[i] = wr; reqAddr[i] = addr;
        reqBe[i] = be; reqWdata[i] = wd; rspReady[i] = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!reqReady[i] && n < 20) begin @(negedge clk); n++; end
        chk("req_accept", 32'(reqReady[i]), 32'd1);
        @(posedge clk); #1;
        reqValid[i] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("cyc1_cs", 32'(sramCs[i]), 32'(!expErr));
                if (!expErr) begin
                    chk("cyc1_we", 32'(sramWe[i]), 32'(wr));
                    chk("cyc1_addr", 32'(sramAddr[i]), 32'(expWord));
                    chk("cyc1_be", 32'(sramBe[i]), 32'(expSramBe));
                end
            end
        end while (!rspValid[i] && lat < 20);
        chk("rsp_latency", 32'(lat), 32'(expLat));
        chk("rsp_data", rspData[i], expData);
        chk("rsp_err", 32'(rspErr[i]), 32'(expErr));
        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                chk("bp_valid", 32'(rspValid[i]), 32'd1);
                chk("bp_data", rspData[i], expData);
                chk("bp_err", 32'(rspErr[i]), 32'(expErr));
                chk("bp_req_ready", 32'(reqReady[i]), 32'd0);
            end
            @(posedge clk); #1;
            rspReady[i] = 1'b1;
            @(negedge clk);
            chk("bp_valid_last", 32'(rspValid[i]), 32'd1);
        end
        @(negedge clk);
        chk("post_valid", 32'(rspValid[i]), 32'd0);
        chk("post_req_ready", 32'(reqReady[i]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0; reqWrite[i] = 1'b0; reqAddr[i] = '0;
            reqBe[i] = '0; reqWdata[i] = '0; rspReady[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full store, byte store, readback, then store/load of DEADBEEF.
        doReq(0, 1'b1, 32'h0001_0008, 4'hF, 32'h1122_3344, 0, 2, 32'h0,         1'b0, 10'd2,   4'hF);
        doReq(0, 1'b1, 32'h0001_000A, 4'b0100, 32'h00AA_0000, 0, 2, 32'h0,      1'b0, 10'd2,   4'b0100);
        doReq(0, 1'b0, 32'h0001_000A, 4'hF, 32'h0, 0, 3, 32'h11AA_3344,        1'b0, 10'd2,   4'hF);
        doReq(0, 1'b1, 32'h0001_0008, 4'hF, 32'hDEAD_BEEF, 0, 2, 32'h0,         1'b0, 10'd2,   4'hF);
        doReq(0, 1'b0, 32'h0001_0008, 4'hF, 32'h0, 0, 3, 32'hDEAD_BEEF,        1'b0, 10'd2,   4'hF);
        // Rejections: below base, one past the top, empty byte enable.
        doReq(0, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0, 0, 1, 32'h0,                1'b1, 10'd0,   4'h0);
        doReq(0, 1'b1, 32'h0001_1000, 4'hF, 32'h5555_5555, 0, 1, 32'h0,         1'b1, 10'd0,   4'h0);
        doReq(0, 1'b0, 32'h0001_0008, 4'h0, 32'h0, 0, 1, 32'h0,                1'b1, 10'd0,   4'h0);
        // Last word in range.
        doReq(0, 1'b0, 32'h0001_0FFC, 4'hF, 32'h0, 0, 3, 32'hA500_03FF,        1'b0, 10'd1023, 4'hF);
        // Response back-pressure.
        doReq(0, 1'b0, 32'h0001_0008, 4'hF, 32'h0, 5, 3, 32'hDEAD_BEEF,        1'b0, 10'd2,   4'hF);

        // Reset during the WAIT cycle of a load; the load must vanish.
        @(posedge clk); #1;
        reqValid[0] = 1'b1; reqWrite[0] = 1'b0; reqAddr[0] = 32'h0001_0004;
        reqBe[0] = 4'hF; rspReady[0] = 1'b1;
        @(negedge clk);
        chk("rst_pre_ready", 32'(reqReady[0]), 32'd1);
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("wait_cs", 32'(sramCs[0]), 32'd0);
        @(negedge clk);
        chk("rst_ready", 32'(reqReady[0]), 32'd0);
        chk("rst_valid", 32'(rspValid[0]), 32'd0);
        chk("rst_addr", 32'(sramAddr[0]), 32'd0);
        chk("rst_wdata", sramWdata[0], 32'd0);
        chk("rst_data", rspData[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_held_ready", 32'(reqReady[0]), 32'd0);
        repeat (6) @(posedge clk);
        doReq(0, 1'b0, 32'h0001_0008, 4'hF, 32'h0, 0, 3, 32'hDEAD_BEEF,        1'b0, 10'd2,   4'hF);

        // RD_LATENCY = 3 instance.
        doReq(1, 1'b0, 32'h0001_001C, 4'hF, 32'h0, 0, 5, 32'hA500_0007,        1'b0, 10'd7,   4'hF);
        doReq(1, 1'b1, 32'h0001_000C, 4'hF, 32'hCAFE_F00D, 0, 2, 32'h0,         1'b0, 10'd3,   4'hF);
        doReq(1, 1'b0, 32'h0001_000C, 4'hF, 32'h0, 0, 5, 32'hCAFE_F00D,        1'b0, 10'd3,   4'hF);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
